// File: rtl/cdr_frame_deser.sv
// +----------------------------------------------------------------------------+
// | Module      : cdr_frame_deser                                              |
// | Description : CDR lock detector, sync-word framer and byte output FIFO.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdr_frame_deser #(
  parameter int          LOCK_THRESH  = 64,
  parameter int          LOCK_COUNT   = 64,
  parameter int          UNLOCK_COUNT = 16,
  parameter logic [7:0]  SYNC_WORD    = 8'hD5,
  parameter int          FRAME_LEN    = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic               d_bb,
  input  logic signed [15:0] f_n,
  output logic [7:0]         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               locked,
  output logic               aligned,
  output logic               overflow
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_gw = $clog2(LOCK_COUNT + 1);
  localparam int c_bw = $clog2(UNLOCK_COUNT + 1);
  localparam int c_fw = $clog2(FRAME_LEN + 1);

  localparam logic [16:0]     c_thresh    = 17'(LOCK_THRESH);
  localparam logic [c_gw-1:0] c_good_last = c_gw'(LOCK_COUNT - 1);
  localparam logic [c_bw-1:0] c_bad_last  = c_bw'(UNLOCK_COUNT - 1);
  localparam logic [c_fw-1:0] c_byte_last = c_fw'(FRAME_LEN - 1);
  localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_cnt_one   = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

  typedef enum logic [0:0] {LK_UNLOCKED = 1'b0, LK_LOCKED = 1'b1} lock_state_t;
  typedef enum logic [0:0] {FR_HUNT = 1'b0, FR_DATA = 1'b1} frame_state_t;

  lock_state_t       r_lock_state;
  logic [c_gw-1:0]   r_good_cnt;
  logic [c_bw-1:0]   r_bad_cnt;
  frame_state_t      r_fr_state;
  logic [2:0]        r_bit_cnt;
  logic [c_fw-1:0]   r_byte_cnt;
  logic [7:0]        r_sr;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic [7:0]        r_m_data;
  logic              r_overflow;

  logic [16:0]       w_fn_abs;
  logic              w_good;
  logic [7:0]        w_byte;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr_en;
  logic              w_drop;
  logic [c_aw-1:0]   w_next_rd;
  logic [c_aw:0]     w_next_count;
  logic [7:0]        w_next_head;

  // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping
  assign w_fn_abs = f_n[15] ? (17'd0 - {1'b1, f_n}) : {1'b0, f_n};
  assign w_good   = (w_fn_abs <= c_thresh);
  assign w_byte   = {r_sr[6:0], d_bb};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_state <= LK_UNLOCKED;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
    end else if (sample_en) begin
      case (r_lock_state)
        LK_UNLOCKED: begin
          if (!w_good) begin
            r_good_cnt <= '0;
          end else if (r_good_cnt == c_good_last) begin
            r_lock_state <= LK_LOCKED;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
          end else begin
            r_good_cnt <= r_good_cnt + c_gw'(1);
          end
        end
        default: begin
          if (w_good) begin
            r_bad_cnt <= '0;
          end else if (r_bad_cnt == c_bad_last) begin
            r_lock_state <= LK_UNLOCKED;
            r_bad_cnt    <= '0;
            r_good_cnt   <= '0;
          end else begin
            r_bad_cnt <= r_bad_cnt + c_bw'(1);
          end
        end
      endcase
    end
  end

  // Framer acts on the lock state as it was before this strobe edge
  assign w_push = sample_en && (r_lock_state == LK_LOCKED) &&
                  (r_fr_state == FR_DATA) && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= '0;
      r_fr_state <= FR_HUNT;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (sample_en) begin
      r_sr <= w_byte;
      if (r_lock_state != LK_LOCKED) begin
        r_fr_state <= FR_HUNT;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
      end else begin
        case (r_fr_state)
          FR_HUNT: begin
            if (w_byte == SYNC_WORD) begin
              r_fr_state <= FR_DATA;
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
            end
          end
          default: begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (r_byte_cnt == c_byte_last) begin
                r_fr_state <= FR_HUNT;
                r_byte_cnt <= '0;
              end else begin
                r_byte_cnt <= r_byte_cnt + c_fw'(1);
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        endcase
      end
    end
  end

  assign w_full    = (r_count == c_depth);
  assign w_pop     = (r_count != '0) && m_ready;
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_next_rd = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

  always_comb begin
    w_next_count = r_count;
    if (w_wr_en && !w_pop) begin
      w_next_count = r_count + c_cnt_one;
    end else if (!w_wr_en && w_pop) begin
      w_next_count = r_count - c_cnt_one;
    end
  end

  // Head after this cycle: the byte being written if it lands in the head slot
  assign w_next_head = (w_wr_en && (w_next_rd == r_wr_ptr)) ? w_byte : r_mem[w_next_rd];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_m_data   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      r_rd_ptr <= w_next_rd;
      r_count  <= w_next_count;
      r_m_data <= (w_next_count == '0) ? 8'd0 : w_next_head;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign m_data   = r_m_data;
  assign m_valid  = (r_count != '0);
  assign locked   = (r_lock_state == LK_LOCKED);
  assign aligned  = (r_fr_state == FR_DATA);
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cdr_frame_deser.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_cdr_frame_deser                                           |
// | Description : Self-checking bench for cdr_frame_deser.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_cdr_frame_deser;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_en;
  logic               d_bb;
  logic signed [15:0] f_n;
  logic [7:0]         m_data;
  logic               m_valid;
  logic               m_ready;
  logic               locked;
  logic               aligned;
  logic               overflow;

  cdr_frame_deser #(
    .LOCK_THRESH  (64),
    .LOCK_COUNT   (64),
    .UNLOCK_COUNT (16),
    .SYNC_WORD    (8'hD5),
    .FRAME_LEN    (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .d_bb      (d_bb),
    .f_n       (f_n),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .locked    (locked),
    .aligned   (aligned),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  // Output snapshot taken 1 ns after the most recent strobe edge
  logic       s_valid, s_locked, s_aligned, s_overflow;
  logic [7:0] s_data;

  typedef struct {
    bit                 do_rst;
    int                 n;
    logic signed [15:0] fn;
    bit                 exp_locked;
  } lock_vec_t;

  lock_vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : sb_mon
    logic [7:0] e;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected none", m_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", {24'd0, m_data}, {24'd0, e});
      end
    end
  end

  task automatic strobe(input logic b, input logic signed [15:0] fn);
    sample_en = 1'b1;
    d_bb      = b;
    f_n       = fn;
    @(posedge clk); #1;
    sample_en  = 1'b0;
    s_valid    = m_valid;
    s_data     = m_data;
    s_locked   = locked;
    s_aligned  = aligned;
    s_overflow = overflow;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    sample_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic lock_up();
    do_reset();
    repeat (64) strobe(1'b0, 16'sd0);
    check("lock_up", {31'd0, locked}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) strobe(b[i], 16'sd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;

    tbl[0]  = '{1'b1, 63, 16'sd0,    1'b0};
    tbl[1]  = '{1'b0, 1,  16'sd0,    1'b1};
    tbl[2]  = '{1'b0, 15, 16'sh8000, 1'b1};
    tbl[3]  = '{1'b0, 1,  16'sd0,    1'b1};
    tbl[4]  = '{1'b0, 15, 16'sh8000, 1'b1};
    tbl[5]  = '{1'b0, 1,  16'sh8000, 1'b0};
    tbl[6]  = '{1'b1, 62, 16'sd0,    1'b0};
    tbl[7]  = '{1'b0, 1,  16'sd100,  1'b0};
    tbl[8]  = '{1'b0, 63, 16'sd0,    1'b0};
    tbl[9]  = '{1'b0, 1,  16'sd0,    1'b1};
    tbl[10] = '{1'b1, 62, 16'sd64,   1'b0};
    tbl[11] = '{1'b0, 1,  16'sd65,   1'b0};
    tbl[12] = '{1'b0, 63, -16'sd64,  1'b0};
    tbl[13] = '{1'b0, 1,  -16'sd64,  1'b1};
    tbl[14] = '{1'b0, 15, 16'sd32767, 1'b1};
    tbl[15] = '{1'b0, 1,  -16'sd65,  1'b0};

    sample_en = 1'b0;
    d_bb      = 1'b0;
    f_n       = 16'sd0;
    m_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_m_valid",  {31'd0, m_valid},  32'd0);
    check("rst_m_data",   {24'd0, m_data},   32'd0);
    check("rst_locked",   {31'd0, locked},   32'd0);
    check("rst_aligned",  {31'd0, aligned},  32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // Lock detector vectors
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].do_rst) do_reset();
      repeat (tbl[i].n) strobe(1'b0, tbl[i].fn);
      check($sformatf("lock_vec%0d", i), {31'd0, locked}, {31'd0, tbl[i].exp_locked});
      check($sformatf("lock_vec%0d_aligned", i), {31'd0, aligned}, 32'd0);
    end

    // Full frame with consumer ready
    m_ready = 1'b1;
    lock_up();
    send_byte(8'hD5);
    check("sync_aligned", {31'd0, s_aligned}, 32'd1);
    check("sync_not_pushed", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i));
      if (i == 14) check("frame_mid_aligned", {31'd0, s_aligned}, 32'd1);
    end
    check("frame_end_aligned", {31'd0, s_aligned}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("a_drained", exp_q.size(), 32'd0);
    check("a_m_valid", {31'd0, m_valid}, 32'd0);

    // Full frame with consumer stalled: overflow
    m_ready = 1'b0;
    lock_up();
    send_byte(8'hD5);
    for (int i = 0; i < 16; i++) begin
      if (i < 4) exp_q.push_back(8'(i));
      send_byte(8'(i));
      if (i == 0) check("push_visible", {31'd0, s_valid}, 32'd1);
      if (i == 1) check("head_held", {24'd0, s_data}, 32'd0);
      if (i == 3) check("full_no_ovf", {31'd0, s_overflow}, 32'd0);
      if (i == 4) check("ovf_set", {31'd0, s_overflow}, 32'd1);
    end
    check("b_aligned", {31'd0, aligned}, 32'd0);
    m_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("b_drained", exp_q.size(), 32'd0);
    check("b_m_valid", {31'd0, m_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Lock lost in the 5th bit of byte 3; sync pattern carried as data
    m_ready = 1'b0;
    lock_up();
    send_byte(8'hD5);
    word = 32'h3CD5_81FF;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'h81);
    for (int j = 0; j < 32; j++) begin
      strobe(word[31-j], (j >= 13 && j <= 28) ? 16'sh8000 : 16'sd0);
      if (j == 27) check("still_locked", {31'd0, s_locked}, 32'd1);
      if (j == 28) check("lock_lost", {31'd0, s_locked}, 32'd0);
    end
    check("c_aligned", {31'd0, aligned}, 32'd0);
    check("c_m_data", {24'd0, m_data}, 32'h3C);
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("c_drained", exp_q.size(), 32'd0);
    check("c_no_partial", {31'd0, m_valid}, 32'd0);

    // Reset while FIFO full and other inputs active
    m_ready = 1'b0;
    lock_up();
    send_byte(8'hD5);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    check("d_full_valid", {31'd0, m_valid}, 32'd1);
    check("d_full_no_ovf", {31'd0, overflow}, 32'd0);
    rst       = 1'b1;
    sample_en = 1'b1;
    d_bb      = 1'b1;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    check("d_rst_m_valid",  {31'd0, m_valid},  32'd0);
    check("d_rst_m_data",   {24'd0, m_data},   32'd0);
    check("d_rst_locked",   {31'd0, locked},   32'd0);
    check("d_rst_aligned",  {31'd0, aligned},  32'd0);
    check("d_rst_overflow", {31'd0, overflow}, 32'd0);
    rst       = 1'b0;
    sample_en = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
